// File: rtl/fp_to_fixed.sv
// rtl/fp_to_fixed.sv - custom float to signed fixed-point decoder, three-stage valid pipeline.
// Optional round-half-away-from-zero when FP_TO_FIXED_ROUND_EN is defined.
module fp_to_fixed #(
  parameter int EXP     = 8,
  parameter int MANT    = 7,
  parameter int WIDTH   = 1 + EXP + MANT,
  parameter int FIXW    = 16,
  parameter int FRAC    = 8,
  parameter int LCYCLES = 3
) (
  input  logic             clock,
  input  logic             clock_sreset_n,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] dataa,
  output logic             result_valid,
  output logic [FIXW-1:0]  result,
  output logic             overflow
);

  localparam int BIAS = 2**(EXP-1) - 1;
  localparam logic signed [EXP+1:0] SH_OFF = (EXP+2)'(FRAC - MANT - BIAS);
  localparam logic signed [EXP+1:0] SH_MAX = (EXP+2)'(FIXW + 1);
  localparam logic [FIXW+1:0] POS_MAX = (FIXW+2)'(2**(FIXW-1) - 1);
  localparam logic [FIXW+1:0] NEG_MAX = (FIXW+2)'(2**(FIXW-1));

  if (LCYCLES != 3) begin : g_bad_lcycles
    $error("fp_to_fixed supports LCYCLES=3 only");
  end

  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_sign_q, s1_sign_d;
  logic [MANT:0]          s1_m_q, s1_m_d;
  logic signed [EXP+1:0]  s1_sh_q, s1_sh_d;

  logic                   s2_valid_q, s2_valid_d;
  logic                   s2_sign_q, s2_sign_d;
  logic [FIXW:0]          s2_mag_q, s2_mag_d;
  logic                   s2_ovf_q, s2_ovf_d;
`ifdef FP_TO_FIXED_ROUND_EN
  logic                   s2_guard_q, s2_guard_d;
`endif

  logic                   result_valid_q, result_valid_d;
  logic [FIXW-1:0]        result_q, result_d;
  logic                   overflow_q, overflow_d;

  // Stage 1: unpack, build the significand and the net shift toward the fixed-point grid.
  always_comb begin
    s1_valid_d = data_valid & clock_sreset_n;
    s1_sign_d  = s1_sign_q;
    s1_m_d     = s1_m_q;
    s1_sh_d    = s1_sh_q;
    if (data_valid) begin
      s1_sign_d = dataa[WIDTH-1];
      s1_m_d    = {(|dataa[WIDTH-2:0]), dataa[MANT-1:0]};
      s1_sh_d   = {2'b00, dataa[WIDTH-2:MANT]} + SH_OFF;
    end
  end

  logic [MANT+FIXW+1:0] s2_wide;
  logic [EXP+1:0]       s2_nsh;
`ifdef FP_TO_FIXED_ROUND_EN
  logic [MANT+1:0]      s2_right;
`else
  logic [MANT:0]        s2_right;
`endif

  // Stage 2: shift; left shifts keep a sticky flag for anything above FIXW+1 bits.
  always_comb begin
    s2_valid_d = s1_valid_q & clock_sreset_n;
    s2_sign_d  = s2_sign_q;
    s2_mag_d   = s2_mag_q;
    s2_ovf_d   = s2_ovf_q;
`ifdef FP_TO_FIXED_ROUND_EN
    s2_guard_d = s2_guard_q;
`endif
    s2_wide  = {{(FIXW+1){1'b0}}, s1_m_q} << s1_sh_q;
    s2_nsh   = -s1_sh_q;
`ifdef FP_TO_FIXED_ROUND_EN
    s2_right = {s1_m_q, 1'b0} >> s2_nsh;
`else
    s2_right = s1_m_q >> s2_nsh;
`endif
    if (s1_valid_q) begin
      s2_sign_d = s1_sign_q;
      if (!s1_sh_q[EXP+1]) begin
        s2_mag_d = s2_wide[FIXW:0];
        s2_ovf_d = (s1_sh_q > SH_MAX) ? (|s1_m_q) : (|s2_wide[MANT+FIXW+1:FIXW+1]);
`ifdef FP_TO_FIXED_ROUND_EN
        s2_guard_d = 1'b0;
`endif
      end else begin
        s2_ovf_d = 1'b0;
`ifdef FP_TO_FIXED_ROUND_EN
        s2_mag_d   = {{(FIXW-MANT){1'b0}}, s2_right[MANT+1:1]};
        s2_guard_d = s2_right[0];
`else
        s2_mag_d   = {{(FIXW-MANT){1'b0}}, s2_right};
`endif
      end
    end
  end

  logic [FIXW+1:0] s3_mag;
  logic            s3_sat;

  // Stage 3: optional rounding, asymmetric saturation, two's-complement negate.
  always_comb begin
    result_valid_d = s2_valid_q & clock_sreset_n;
    result_d       = result_q;
    overflow_d     = overflow_q;
`ifdef FP_TO_FIXED_ROUND_EN
    s3_mag = {1'b0, s2_mag_q} + {{(FIXW+1){1'b0}}, s2_guard_q};
`else
    s3_mag = {1'b0, s2_mag_q};
`endif
    s3_sat = s2_ovf_q | (s2_sign_q ? (s3_mag > NEG_MAX) : (s3_mag > POS_MAX));
    if (s2_valid_q) begin
      overflow_d = s3_sat;
      if (s3_sat) begin
        result_d = s2_sign_q ? {1'b1, {(FIXW-1){1'b0}}} : {1'b0, {(FIXW-1){1'b1}}};
      end else begin
        result_d = s2_sign_q ? -s3_mag[FIXW-1:0] : s3_mag[FIXW-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!clock_sreset_n) begin
      s1_valid_q     <= 1'b0;
      s1_sign_q      <= 1'b0;
      s1_m_q         <= '0;
      s1_sh_q        <= '0;
      s2_valid_q     <= 1'b0;
      s2_sign_q      <= 1'b0;
      s2_mag_q       <= '0;
      s2_ovf_q       <= 1'b0;
`ifdef FP_TO_FIXED_ROUND_EN
      s2_guard_q     <= 1'b0;
`endif
      result_valid_q <= 1'b0;
      result_q       <= '0;
      overflow_q     <= 1'b0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_sign_q      <= s1_sign_d;
      s1_m_q         <= s1_m_d;
      s1_sh_q        <= s1_sh_d;
      s2_valid_q     <= s2_valid_d;
      s2_sign_q      <= s2_sign_d;
      s2_mag_q       <= s2_mag_d;
      s2_ovf_q       <= s2_ovf_d;
`ifdef FP_TO_FIXED_ROUND_EN
      s2_guard_q     <= s2_guard_d;
`endif
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      overflow_q     <= overflow_d;
    end
  end

  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign overflow     = result_valid_q & overflow_q;

endmodule
